// File: rtl/core_bus_arb.sv
// core_bus_arb: round-robin fetch/LSU arbiter onto NUM_SLV address-decoded regions, one read outstanding (console write via CORE_BUS_CONSOLE_EN).
// Latency: grant and slave strobes are combinational; responses are registered one cycle after slv_rvld, decode miss or timeout.
// Backpressure: requesters hold req_en until gnt; both grants stay low while a read is outstanding.
module core_bus_arb #(
  parameter int NUM_SLV    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE = {32'hFFFF_1000, 32'hFFFF_0000},
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_LEN  = {32'h0000_1000, 32'h0000_1000},
  parameter int TIMEOUT    = 16,
  parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR = 32'hFFFF_2000
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          inst_req_en,
  input  logic [ADDR_WIDTH-1:0]         inst_req_addr,
  output logic                          inst_req_gnt,
  output logic [DATA_WIDTH-1:0]         inst_rsp_rdata,
  output logic                          inst_rsp_rvld,
  output logic                          inst_rsp_err,
  input  logic                          lsu_req_en,
  input  logic [ADDR_WIDTH-1:0]         lsu_req_addr,
  input  logic [DATA_WIDTH-1:0]         lsu_req_wdata,
  input  logic [STRB_WIDTH-1:0]         lsu_req_wen,
  output logic                          lsu_req_gnt,
  output logic [DATA_WIDTH-1:0]         lsu_rsp_rdata,
  output logic                          lsu_rsp_rvld,
  output logic                          lsu_rsp_err,
  output logic [NUM_SLV-1:0]            slv_en,
  output logic [ADDR_WIDTH-1:0]         slv_addr,
  output logic [DATA_WIDTH-1:0]         slv_wdata,
  output logic [STRB_WIDTH-1:0]         slv_wen,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] slv_rdata,
  input  logic [NUM_SLV-1:0]            slv_rvld
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
`ifdef CORE_BUS_CONSOLE_EN
  localparam logic CONSOLE_EN = 1'b1;
`else
  localparam logic CONSOLE_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state, state_nxt;
  logic                    last_lsu;
  logic                    owner_lsu;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        cnt;

  logic                    sel_lsu;
  logic                    req_any;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [STRB_WIDTH-1:0]   req_wen;
  logic                    req_write;
  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic                    con_match;
  logic                    console_hit;
  logic                    dec_err;
  logic                    slv_go;
  logic                    rsp_hit;
  logic [DATA_WIDTH-1:0]   rd_data;

  // On a conflict the requester that did not win last time gets the bus.
  always_comb begin
    sel_lsu = 1'b0;
    if (inst_req_en && lsu_req_en) sel_lsu = ~last_lsu;
    else                           sel_lsu = lsu_req_en;
  end

  assign req_any   = (state == S_IDLE) && (inst_req_en || lsu_req_en);
  assign req_addr  = sel_lsu ? lsu_req_addr : inst_req_addr;
  assign req_wen   = sel_lsu ? lsu_req_wen : '0;
  assign req_write = |req_wen;

  // Descending scan so the lowest matching region wins; 33-bit compare avoids wrap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (({1'b0, req_addr} >= {1'b0, SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]}) &&
          ({1'b0, req_addr} <  ({1'b0, SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]} +
                                {1'b0, SLV_LEN[i*ADDR_WIDTH +: ADDR_WIDTH]}))) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign con_match   = (req_addr == CONSOLE_ADDR);
  assign console_hit = CONSOLE_EN && sel_lsu && req_write && con_match;
  assign dec_err     = !console_hit && (!hit || (CONSOLE_EN && con_match));
  assign slv_go      = req_any && !console_hit && !dec_err;

  assign inst_req_gnt = req_any && !sel_lsu;
  assign lsu_req_gnt  = req_any && sel_lsu;

  always_comb begin
    slv_en    = '0;
    slv_addr  = '0;
    slv_wdata = '0;
    slv_wen   = '0;
    if (slv_go) begin
      slv_en[hit_idx] = 1'b1;
      slv_addr        = req_addr;
      slv_wdata       = sel_lsu ? lsu_req_wdata : '0;
      slv_wen         = req_wen;
    end
  end

  assign rsp_hit = slv_rvld[idx];
  assign rd_data = slv_rdata[int'(idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (slv_go && !req_write) state_nxt = S_WAIT;
      S_WAIT: if (rsp_hit || cnt == CNT_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      last_lsu       <= 1'b0;
      owner_lsu      <= 1'b0;
      idx            <= '0;
      cnt            <= '0;
      inst_rsp_rdata <= '0;
      inst_rsp_rvld  <= 1'b0;
      inst_rsp_err   <= 1'b0;
      lsu_rsp_rdata  <= '0;
      lsu_rsp_rvld   <= 1'b0;
      lsu_rsp_err    <= 1'b0;
    end else begin
      inst_rsp_rvld <= 1'b0;
      inst_rsp_err  <= 1'b0;
      lsu_rsp_rvld  <= 1'b0;
      lsu_rsp_err   <= 1'b0;
      if (state == S_IDLE) begin
        if (req_any) begin
          last_lsu <= sel_lsu;
          if (dec_err) begin
            if (sel_lsu) begin
              lsu_rsp_err <= 1'b1;
              if (!req_write) begin
                lsu_rsp_rvld  <= 1'b1;
                lsu_rsp_rdata <= '0;
              end
            end else begin
              inst_rsp_err   <= 1'b1;
              inst_rsp_rvld  <= 1'b1;
              inst_rsp_rdata <= '0;
            end
          end else if (slv_go && !req_write) begin
            owner_lsu <= sel_lsu;
            idx       <= hit_idx;
            cnt       <= '0;
          end
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
        // Data arriving on the last wait cycle beats the timeout.
        if (rsp_hit || cnt == CNT_LAST) begin
          if (owner_lsu) begin
            lsu_rsp_rvld  <= 1'b1;
            lsu_rsp_err   <= !rsp_hit;
            lsu_rsp_rdata <= rsp_hit ? rd_data : '0;
          end else begin
            inst_rsp_rvld  <= 1'b1;
            inst_rsp_err   <= !rsp_hit;
            inst_rsp_rdata <= rsp_hit ? rd_data : '0;
          end
        end
      end
    end
  end

`ifdef CORE_BUS_CONSOLE_EN
  always_ff @(posedge CLK) begin
    if (RSTN && req_any && console_hit) $write("%c", lsu_req_wdata[7:0]);
  end
`endif

endmodule

// File: tb/tb_core_bus_arb.sv
// Directed bench for core_bus_arb: fetch/LSU reads, posted writes, decode errors,
// round-robin conflicts, timeout and async reset; inputs driven on negedge.
module tb_core_bus_arb;

  logic        CLK;
  logic        RSTN;
  logic        inst_req_en;
  logic [31:0] inst_req_addr;
  logic        inst_req_gnt;
  logic [31:0] inst_rsp_rdata;
  logic        inst_rsp_rvld;
  logic        inst_rsp_err;
  logic        lsu_req_en;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wen;
  logic        lsu_req_gnt;
  logic [31:0] lsu_rsp_rdata;
  logic        lsu_rsp_rvld;
  logic        lsu_rsp_err;
  logic [1:0]  slv_en;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [3:0]  slv_wen;
  logic [63:0] slv_rdata;
  logic [1:0]  slv_rvld;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  core_bus_arb dut (
    .CLK(CLK), .RSTN(RSTN),
    .inst_req_en(inst_req_en), .inst_req_addr(inst_req_addr), .inst_req_gnt(inst_req_gnt),
    .inst_rsp_rdata(inst_rsp_rdata), .inst_rsp_rvld(inst_rsp_rvld), .inst_rsp_err(inst_rsp_err),
    .lsu_req_en(lsu_req_en), .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_wen(lsu_req_wen), .lsu_req_gnt(lsu_req_gnt), .lsu_rsp_rdata(lsu_rsp_rdata),
    .lsu_rsp_rvld(lsu_rsp_rvld), .lsu_rsp_err(lsu_rsp_err),
    .slv_en(slv_en), .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_wen(slv_wen),
    .slv_rdata(slv_rdata), .slv_rvld(slv_rvld)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    inst_req_en = 0; inst_req_addr = 0;
    lsu_req_en = 0; lsu_req_addr = 0; lsu_req_wdata = 0; lsu_req_wen = 0;
    slv_rdata = 0; slv_rvld = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    clear_inputs();
    RSTN = 0;
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1;
  endtask

  task automatic test_reset();
    do_reset();
    RSTN = 0;
    #1;
    chk_cnt++;
    if ({inst_req_gnt, inst_rsp_rvld, inst_rsp_err, lsu_req_gnt, lsu_rsp_rvld, lsu_rsp_err} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000",
               {inst_req_gnt, inst_rsp_rvld, inst_rsp_err, lsu_req_gnt, lsu_rsp_rvld, lsu_rsp_err});
    else pass_cnt++;
    chk_cnt++;
    if ({inst_rsp_rdata, lsu_rsp_rdata} !== 64'b0)
      $display("FAIL reset_rdata: got %h want 0", {inst_rsp_rdata, lsu_rsp_rdata});
    else pass_cnt++;
    chk_cnt++;
    if ({slv_en, slv_addr, slv_wdata, slv_wen} !== 70'b0)
      $display("FAIL reset_slv: got %h want 0", {slv_en, slv_addr, slv_wdata, slv_wen});
    else pass_cnt++;
    @(negedge CLK);
    RSTN = 1;
  endtask

  task automatic test_fetch_read();
    @(negedge CLK);
    inst_req_en = 1; inst_req_addr = 32'hFFFF_0004;
    #1;
    chk_cnt++;
    if ({inst_req_gnt, lsu_req_gnt, slv_en} !== 4'b1001)
      $display("FAIL fetch_gnt: got gnt/lsu/en=%b want 1001", {inst_req_gnt, lsu_req_gnt, slv_en});
    else pass_cnt++;
    chk_cnt++;
    if (slv_addr !== 32'hFFFF_0004 || slv_wen !== 4'b0)
      $display("FAIL fetch_slv_addr: got %h/%b want ffff0004/0000", slv_addr, slv_wen);
    else pass_cnt++;
    @(negedge CLK);
    inst_req_en = 0;
    inst_req_en = 1;
    #1;
    chk_cnt++;
    if ({inst_req_gnt, slv_en} !== 3'b000)
      $display("FAIL fetch_wait_blocks: got gnt/en=%b want 000", {inst_req_gnt, slv_en});
    else pass_cnt++;
    inst_req_en = 0;
    @(negedge CLK);
    slv_rvld = 2'b01; slv_rdata = {32'h0, 32'h0000_0013};
    @(negedge CLK);
    slv_rvld = 0; slv_rdata = 0;
    chk_cnt++;
    if ({inst_rsp_rvld, inst_rsp_err} !== 2'b10 || inst_rsp_rdata !== 32'h13)
      $display("FAIL fetch_rsp: got rvld/err=%b data=%h want 10/00000013",
               {inst_rsp_rvld, inst_rsp_err}, inst_rsp_rdata);
    else pass_cnt++;
    @(negedge CLK);
    chk_cnt++;
    if (inst_rsp_rvld !== 1'b0 || inst_rsp_rdata !== 32'h13)
      $display("FAIL fetch_hold: got rvld=%b data=%h want 0/00000013", inst_rsp_rvld, inst_rsp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_lsu_read();
    @(negedge CLK);
    lsu_req_en = 1; lsu_req_addr = 32'hFFFF_1010; lsu_req_wen = 0;
    #1;
    chk_cnt++;
    if ({lsu_req_gnt, slv_en} !== 3'b110)
      $display("FAIL lsu_rd_gnt: got gnt/en=%b want 110", {lsu_req_gnt, slv_en});
    else pass_cnt++;
    @(negedge CLK);
    lsu_req_en = 0;
    slv_rvld = 2'b01; slv_rdata = {32'h0, 32'h0000_1111};
    @(negedge CLK);
    chk_cnt++;
    if (lsu_rsp_rvld !== 1'b0)
      $display("FAIL lsu_rd_other_slave: got rvld=%b want 0", lsu_rsp_rvld);
    else pass_cnt++;
    slv_rvld = 2'b10; slv_rdata = {32'hDEAD_BEEF, 32'h0000_1111};
    @(negedge CLK);
    slv_rvld = 0; slv_rdata = 0;
    chk_cnt++;
    if ({lsu_rsp_rvld, lsu_rsp_err} !== 2'b10 || lsu_rsp_rdata !== 32'hDEAD_BEEF)
      $display("FAIL lsu_rd_rsp: got rvld/err=%b data=%h want 10/deadbeef",
               {lsu_rsp_rvld, lsu_rsp_err}, lsu_rsp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_lsu_write();
    @(negedge CLK);
    lsu_req_en = 1; lsu_req_addr = 32'hFFFF_1008; lsu_req_wen = 4'b0011; lsu_req_wdata = 32'hA5A5_1234;
    #1;
    chk_cnt++;
    if ({lsu_req_gnt, slv_en, slv_wen} !== 7'b1_10_0011)
      $display("FAIL wr_gnt: got gnt/en/wen=%b want 1100011", {lsu_req_gnt, slv_en, slv_wen});
    else pass_cnt++;
    chk_cnt++;
    if (slv_addr !== 32'hFFFF_1008 || slv_wdata !== 32'hA5A5_1234)
      $display("FAIL wr_bus: got addr=%h data=%h want ffff1008/a5a51234", slv_addr, slv_wdata);
    else pass_cnt++;
    @(negedge CLK);
    lsu_req_en = 0; lsu_req_wen = 0; lsu_req_wdata = 0;
    chk_cnt++;
    if ({lsu_rsp_rvld, lsu_rsp_err, inst_rsp_rvld} !== 3'b000)
      $display("FAIL wr_no_rsp: got %b want 000", {lsu_rsp_rvld, lsu_rsp_err, inst_rsp_rvld});
    else pass_cnt++;
  endtask

  task automatic test_miss_read();
    @(negedge CLK);
    lsu_req_en = 1; lsu_req_addr = 32'h0000_0000; lsu_req_wen = 0;
    #1;
    chk_cnt++;
    if ({lsu_req_gnt, slv_en} !== 3'b100)
      $display("FAIL miss_gnt: got gnt/en=%b want 100", {lsu_req_gnt, slv_en});
    else pass_cnt++;
    @(negedge CLK);
    lsu_req_en = 0;
    chk_cnt++;
    if ({lsu_rsp_rvld, lsu_rsp_err} !== 2'b11 || lsu_rsp_rdata !== 32'h0)
      $display("FAIL miss_rsp: got rvld/err=%b data=%h want 11/00000000",
               {lsu_rsp_rvld, lsu_rsp_err}, lsu_rsp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    bit early = 0;
    @(negedge CLK);
    lsu_req_en = 1; lsu_req_addr = 32'hFFFF_1000; lsu_req_wen = 0;
    #1;
    chk_cnt++;
    if (lsu_req_gnt !== 1'b1)
      $display("FAIL to_gnt: got %b want 1", lsu_req_gnt);
    else pass_cnt++;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      lsu_req_en = 0;
      if (lsu_rsp_err !== 1'b0 || lsu_rsp_rvld !== 1'b0) early = 1;
    end
    chk_cnt++;
    if (early) $display("FAIL to_early: got response before cycle 17 want none");
    else pass_cnt++;
    @(negedge CLK);
    chk_cnt++;
    if ({lsu_rsp_rvld, lsu_rsp_err} !== 2'b11 || lsu_rsp_rdata !== 32'h0)
      $display("FAIL to_err: got rvld/err=%b data=%h want 11/00000000",
               {lsu_rsp_rvld, lsu_rsp_err}, lsu_rsp_rdata);
    else pass_cnt++;
    inst_req_en = 1; inst_req_addr = 32'hFFFF_0000;
    #1;
    chk_cnt++;
    if ({inst_req_gnt, slv_en} !== 3'b101)
      $display("FAIL b2b_gnt: got gnt/en=%b want 101", {inst_req_gnt, slv_en});
    else pass_cnt++;
    @(negedge CLK);
    inst_req_en = 0;
    chk_cnt++;
    if (lsu_rsp_err !== 1'b0)
      $display("FAIL to_pulse: got err=%b want 0", lsu_rsp_err);
    else pass_cnt++;
    slv_rvld = 2'b01; slv_rdata = {32'h0, 32'h0000_0055};
    @(negedge CLK);
    slv_rvld = 0; slv_rdata = 0;
    chk_cnt++;
    if ({inst_rsp_rvld, inst_rsp_err} !== 2'b10 || inst_rsp_rdata !== 32'h55)
      $display("FAIL b2b_rsp: got rvld/err=%b data=%h want 10/00000055",
               {inst_rsp_rvld, inst_rsp_err}, inst_rsp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_timeout_race();
    @(negedge CLK);
    lsu_req_en = 1; lsu_req_addr = 32'hFFFF_1004; lsu_req_wen = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK);
      lsu_req_en = 0;
    end
    @(negedge CLK);
    slv_rvld = 2'b10; slv_rdata = {32'h0000_7777, 32'h0};
    @(negedge CLK);
    slv_rvld = 0; slv_rdata = 0;
    chk_cnt++;
    if ({lsu_rsp_rvld, lsu_rsp_err} !== 2'b10 || lsu_rsp_rdata !== 32'h7777)
      $display("FAIL race_rsp: got rvld/err=%b data=%h want 10/00007777",
               {lsu_rsp_rvld, lsu_rsp_err}, lsu_rsp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge CLK);
    inst_req_en = 1; inst_req_addr = 32'h0000_0100;
    lsu_req_en = 1; lsu_req_addr = 32'hFFFF_1000; lsu_req_wen = 4'b1111; lsu_req_wdata = 32'h1;
    #1;
    chk_cnt++;
    if ({lsu_req_gnt, inst_req_gnt} !== 2'b10)
      $display("FAIL rr_1: got lsu/inst=%b want 10", {lsu_req_gnt, inst_req_gnt});
    else pass_cnt++;
    @(negedge CLK);
    #1;
    chk_cnt++;
    if ({lsu_req_gnt, inst_req_gnt} !== 2'b01)
      $display("FAIL rr_2: got lsu/inst=%b want 01", {lsu_req_gnt, inst_req_gnt});
    else pass_cnt++;
    @(negedge CLK);
    #1;
    chk_cnt++;
    if ({lsu_req_gnt, inst_req_gnt} !== 2'b10)
      $display("FAIL rr_3: got lsu/inst=%b want 10", {lsu_req_gnt, inst_req_gnt});
    else pass_cnt++;
    chk_cnt++;
    if ({inst_rsp_rvld, inst_rsp_err} !== 2'b11 || inst_rsp_rdata !== 32'h0)
      $display("FAIL rr_inst_miss: got rvld/err=%b data=%h want 11/00000000",
               {inst_rsp_rvld, inst_rsp_err}, inst_rsp_rdata);
    else pass_cnt++;
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    lsu_req_en = 1; lsu_req_addr = 32'hFFFF_0010; lsu_req_wen = 0;
    @(negedge CLK);
    lsu_req_en = 0;
    RSTN = 0;
    #1;
    chk_cnt++;
    if ({lsu_req_gnt, inst_req_gnt, lsu_rsp_rvld, lsu_rsp_err, slv_en} !== 6'b0 ||
        {lsu_rsp_rdata, slv_addr} !== 64'b0)
      $display("FAIL rst_mid: got ctrl=%b data=%h want 0",
               {lsu_req_gnt, inst_req_gnt, lsu_rsp_rvld, lsu_rsp_err, slv_en}, {lsu_rsp_rdata, slv_addr});
    else pass_cnt++;
    @(negedge CLK);
    RSTN = 1;
    slv_rvld = 2'b01; slv_rdata = {32'h0, 32'h0000_9999};
    @(negedge CLK);
    slv_rvld = 0; slv_rdata = 0;
    chk_cnt++;
    if (lsu_rsp_rvld !== 1'b0)
      $display("FAIL rst_lost: got rvld=%b want 0", lsu_rsp_rvld);
    else pass_cnt++;
    lsu_req_en = 1; lsu_req_addr = 32'hFFFF_0020;
    #1;
    chk_cnt++;
    if ({lsu_req_gnt, slv_en} !== 3'b101)
      $display("FAIL rst_regnt: got gnt/en=%b want 101", {lsu_req_gnt, slv_en});
    else pass_cnt++;
    @(negedge CLK);
    lsu_req_en = 0;
    slv_rvld = 2'b01; slv_rdata = {32'h0, 32'h0000_ABCD};
    @(negedge CLK);
    slv_rvld = 0; slv_rdata = 0;
    chk_cnt++;
    if ({lsu_rsp_rvld, lsu_rsp_err} !== 2'b10 || lsu_rsp_rdata !== 32'hABCD)
      $display("FAIL rst_resume: got rvld/err=%b data=%h want 10/0000abcd",
               {lsu_rsp_rvld, lsu_rsp_err}, lsu_rsp_rdata);
    else pass_cnt++;
  endtask

  initial begin
    RSTN = 0;
    clear_inputs();
    test_reset();
    test_fetch_read();
    test_lsu_read();
    test_lsu_write();
    test_miss_read();
    test_timeout();
    test_timeout_race();
    test_round_robin();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
